// File: rtl/pc_gen.sv
// pc_gen: instruction fetch address generator.
//
// Produces the fetch address (pc) and the instruction-memory chip enable (ce).
// After reset the block sits in BOOT for one edge, with ce low and pc at
// RESET_VEC. It then enters RUN and stays there until the next reset.
// In RUN the pc advances when the pipeline is not stalled and memory has
// accepted the current address. Redirects are applied in this priority order:
//   1. flush (always applied)
//   2. branch (applied on advance)
//   3. pending branch (applied on advance)
//   4. sequential increment (on advance)
// A branch that arrives while fetch is held is parked in a pending register
// and replayed on the next advance.
//
// Ports
//   clk                      clock, rising edge
//   rst                      asynchronous reset, active-low
//   stall[STALL_W-1:0]       pipeline stall vector; only bit 0 holds fetch
//   imem_ack_i               memory accepted the current pc this cycle
//   branch_flag_i            branch/jump taken (one-cycle pulse)
//   branch_target_address_i  branch destination
//   flush_i                  exception/eret redirect (one-cycle pulse)
//   new_pc_i                 flush destination
//   pc                       current fetch address (registered)
//   ce                       memory chip enable, high in RUN
//   pend_o                   a deferred branch redirect is held
//   align_err_o              pulse: the last loaded redirect target was misaligned
module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter int                STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STALL_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               imem_ack_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               pend_o,
    output logic               align_err_o
);

    localparam logic [0:0] S_BOOT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Low-order bits that must be zero in any fetch address.
    // This mask is zero when STEP == 1.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);

    logic [0:0]        state;
    logic [ADDR_W-1:0] pend_addr;

    logic              advance;
    logic              load;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_next;
    logic              pend_next;
    logic [ADDR_W-1:0] pend_addr_next;
    logic              align_err_next;

    assign ce      = (state == S_RUN);
    assign advance = ce & ~stall[0] & imem_ack_i;

    always_comb begin
        load           = 1'b0;
        target         = '0;
        pc_next        = pc;
        pend_next      = pend_o;
        pend_addr_next = pend_addr;
        align_err_next = 1'b0;

        if (state == S_RUN) begin
            if (flush_i) begin
                load      = 1'b1;
                target    = new_pc_i;
                pend_next = 1'b0;
            end else if (advance) begin
                pend_next = 1'b0;
                if (branch_flag_i) begin
                    load   = 1'b1;
                    target = branch_target_address_i;
                end else if (pend_o) begin
                    load   = 1'b1;
                    target = pend_addr;
                end else begin
                    pc_next = pc + STEP_V;
                end
            end else if (branch_flag_i) begin
                // Fetch is held, so park the branch target.
                // A later held branch overwrites it.
                pend_next      = 1'b1;
                pend_addr_next = branch_target_address_i;
            end
        end

        // Alignment is judged when a target is loaded into pc.
        // It is not judged when the target is parked.
        if (load) begin
            pc_next        = target & ~LOW_MASK;
            align_err_next = |(target & LOW_MASK);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_BOOT;
            pc          <= RESET_VEC;
            pend_o      <= 1'b0;
            pend_addr   <= '0;
            align_err_o <= 1'b0;
        end else begin
            state       <= S_RUN;
            pc          <= pc_next;
            pend_o      <= pend_next;
            pend_addr   <= pend_addr_next;
            align_err_o <= align_err_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen at default parameters.
//
// A behavioural model tracks the architectural fetch address, the pending
// redirect and the alignment flag. The model's outputs are compared with the
// DUT on every falling clock edge. Hand-computed literal expectations at key
// points pin both the model and the DUT.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        imem_ack_i = 1'b1;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic [31:0] pc;
    logic        ce;
    logic        pend_o;
    logic        align_err_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    pc_gen dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .imem_ack_i              (imem_ack_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .flush_i                 (flush_i),
        .new_pc_i                (new_pc_i),
        .pc                      (pc),
        .ce                      (ce),
        .pend_o                  (pend_o),
        .align_err_o             (align_err_o)
    );

    always #5 clk = ~clk;

    // Behavioural model.
    // Fetch addresses are plain 32-bit byte addresses and the stride is 4.
    bit          m_run   = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    bit          m_pend  = 1'b0;
    logic [31:0] m_paddr = 32'h0;
    bit          m_aerr  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run   <= 1'b0;
            m_pc    <= 32'h0;
            m_pend  <= 1'b0;
            m_paddr <= 32'h0;
            m_aerr  <= 1'b0;
        end else begin
            logic [31:0] dest;
            bit          go;
            bit          jump;
            go   = m_run && !stall[0] && imem_ack_i;
            jump = 1'b0;
            dest = m_pc;
            if (m_run && flush_i) begin
                jump = 1'b1;
                dest = new_pc_i;
            end else if (go && branch_flag_i) begin
                jump = 1'b1;
                dest = branch_target_address_i;
            end else if (go && m_pend) begin
                jump = 1'b1;
                dest = m_paddr;
            end else if (go) begin
                dest = m_pc + 32'd4;
            end

            m_pc   <= jump ? {dest[31:2], 2'b00} : dest;
            m_aerr <= jump && (dest[1:0] != 2'b00);

            if (m_run && !flush_i && !go && branch_flag_i) begin
                m_pend  <= 1'b1;
                m_paddr <= branch_target_address_i;
            end else if (m_run && (flush_i || go)) begin
                m_pend <= 1'b0;
            end
            m_run <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pc",   pc,                 m_pc);
            chk("model_ce",   32'(ce),            32'(m_run));
            chk("model_pend", 32'(pend_o),        32'(m_pend));
            chk("model_aerr", 32'(align_err_o),   32'(m_aerr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low.
        step();
        step();
        chk("rst_pc",   pc,                 32'h0);
        chk("rst_ce",   32'(ce),            32'h0);
        chk("rst_pend", 32'(pend_o),        32'h0);
        chk("rst_aerr", 32'(align_err_o),   32'h0);
        cmp_en = 1'b1;

        // Reset release: BOOT for one edge, then sequential fetch.
        rst = 1'b1;
        #2;
        chk("boot_ce", 32'(ce), 32'h0);
        chk("boot_pc", pc,      32'h0);
        step();
        chk("run_ce",  32'(ce), 32'h1);
        chk("run_pc0", pc,      32'h0);
        step();
        chk("run_pc4", pc,      32'h4);
        step();
        chk("run_pc8", pc,      32'h8);
        step();
        step();
        chk("run_pc10", pc,     32'h10);

        // A branch under stall is deferred.
        stall = 6'b000001;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h200;
        step();
        branch_flag_i = 1'b0;
        chk("defer_pc",   pc,            32'h10);
        chk("defer_pend", 32'(pend_o),   32'h1);
        step();
        chk("defer_hold", pc,            32'h10);

        // A flush overrides the pending branch and the stall.
        flush_i = 1'b1;
        new_pc_i = 32'h180;
        step();
        flush_i = 1'b0;
        chk("flush_pc",   pc,            32'h180);
        chk("flush_pend", 32'(pend_o),   32'h0);

        // Defer again, then release the stall.
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h200;
        step();
        branch_flag_i = 1'b0;
        chk("defer2_pend", 32'(pend_o),  32'h1);
        stall = '0;
        step();
        chk("release_pc",   pc,          32'h200);
        chk("release_pend", 32'(pend_o), 32'h0);
        step();
        chk("release_seq",  pc,          32'h204);

        // Address wrap, including cycles with no memory ack.
        flush_i = 1'b1;
        new_pc_i = 32'hFFFF_FFFC;
        step();
        flush_i = 1'b0;
        imem_ack_i = 1'b0;
        chk("wrap_load", pc, 32'hFFFF_FFFC);
        step();
        step();
        chk("noack_hold", pc, 32'hFFFF_FFFC);
        imem_ack_i = 1'b1;
        step();
        chk("wrap_pc", pc, 32'h0);

        // A misaligned branch on advance.
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h103;
        step();
        branch_flag_i = 1'b0;
        chk("mis_pc",   pc,                 32'h100);
        chk("mis_aerr", 32'(align_err_o),   32'h1);
        step();
        chk("mis_aerr_clr", 32'(align_err_o), 32'h0);
        chk("mis_seq",      pc,               32'h104);

        // A misaligned pending target is flagged when loaded, not when latched.
        stall = 6'b000001;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h2A2;
        step();
        branch_flag_i = 1'b0;
        chk("latch_aerr", 32'(align_err_o), 32'h0);
        stall = '0;
        step();
        chk("pload_pc",   pc,               32'h2A0);
        chk("pload_aerr", 32'(align_err_o), 32'h1);

        // With a branch pending, a new branch on advance takes precedence.
        stall = 6'b000001;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h300;
        step();
        stall = '0;
        branch_target_address_i = 32'h400;
        step();
        branch_flag_i = 1'b0;
        chk("bpend_pc",   pc,          32'h400);
        chk("bpend_pend", 32'(pend_o), 32'h0);

        // Asynchronous reset in the middle of a cycle, with a branch pending.
        stall = 6'b000001;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h500;
        step();
        branch_flag_i = 1'b0;
        chk("pre_arst_pend", 32'(pend_o), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_pc",   pc,          32'h0);
        chk("arst_ce",   32'(ce),     32'h0);
        chk("arst_pend", 32'(pend_o), 32'h0);
        stall = '0;
        rst = 1'b1;

        // A flush arriving in BOOT is ignored.
        flush_i = 1'b1;
        new_pc_i = 32'h80;
        step();
        flush_i = 1'b0;
        chk("boot_flush_pc",   pc,          32'h0);
        chk("boot_flush_pend", 32'(pend_o), 32'h0);
        step();
        chk("post_arst_pc", pc, 32'h4);
        step();
        step();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
